occupancy_update: RTL
=====================

Name: occupancy_update

Overview:
- Consumes the per-cell stream from the ray tracer: one x/y index plus a free/occupied flag per write_enable pulse.
- Performs a pipelined read-modify-write of the signed log-odds value held in the occupancy map RAM.
- Sustains one update per cycle with full read-after-write forwarding.
- Also provides a map-clear sweep controlled by a small FSM.

Parameters:
- INDEX_W, 8, width of x/y cell index (matches ram_pkg::index_t); map is 2^INDEX_W x 2^INDEX_W.
- CELL_W, 8, signed log-odds cell width.
- L_FREE, 3, amount subtracted on a free update.
- L_OCC, 9, amount added on an occupied update.
- L_MIN, -127, lower clamp.
- L_MAX, 127, upper clamp.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- x_index  in  INDEX_W  cell column from tracer
- y_index  in  INDEX_W  cell row from tracer
- cell_is_free  in  1  1 = free update, 0 = occupied update
- write_enable  in  1  update request strobe; no backpressure exists
- clear_start  in  1  request full-map clear
- map_rd_en  out  1  RAM read enable
- map_rd_addr  out  2*INDEX_W  read address = {y_index, x_index}
- map_rd_data  in  CELL_W  RAM read data, valid the cycle after map_rd_en
- map_wr_en  out  1  RAM write enable
- map_wr_addr  out  2*INDEX_W  write address
- map_wr_data  out  CELL_W  write data (signed)
- busy  out  1  FSM not IDLE or any pipeline stage valid
- overrun  out  1  sticky: a request was dropped

Behaviour:
- RAM model: simple dual-port, 1-cycle synchronous read, read-during-write to the same address returns OLD data.
- Reset: FSM=IDLE; all stage valids=0; map_rd_en, map_wr_en, busy, overrun=0; addresses and data=0.
- Pipeline, request A accepted at cycle N:
  - N: map_rd_en=1 and map_rd_addr={y,x}, combinationally from the inputs. Accepted only in IDLE.
  - N+1 (S1): old value = forwarded or map_rd_data. new = clamp(old + (free ? -L_FREE : +L_OCC)). Computed at CELL_W+2 bits and clamped to [L_MIN, L_MAX].
  - N+2 (S2): registered result; map_wr_en=1 with address and data of A.
  - N+3: A's address and data are held in register W (last completed write).
  - Latency is 2 cycles from request to write. Throughput is 1 per cycle.
- Forwarding for S1's old value, in priority order:
  - S2 valid and same address: use S2 data.
  - Else W valid and same address: use W data.
  - Else use map_rd_data.
- Consequence: back-to-back updates to one cell accumulate exactly. Example: three consecutive occupied updates from 0 give 9, 18, 27.
- FSM states:
  - IDLE: accepts requests. clear_start=1 goes to DRAIN and clears overrun. If write_enable and clear_start are high in the same cycle, the request is accepted and the clear then proceeds.
  - DRAIN: requests not accepted. Stays until S1 and S2 are both empty (at most 2 cycles), then goes to CLEAR with the counter at 0.
  - CLEAR: map_wr_en=1, map_wr_addr=counter, map_wr_data=0, one cell per cycle. After address 2^(2*INDEX_W)-1 is written, goes to IDLE and invalidates W. A full sweep takes 2^(2*INDEX_W) cycles.
- Drops: write_enable in DRAIN or CLEAR drops the request, issues no read, and sets overrun. overrun clears only on reset or on an accepted clear_start.
- clear_start outside IDLE is ignored.
- Reset mid-CLEAR: the sweep aborts immediately with no further writes. The map is partially cleared; the caller must reissue clear_start.
- Saturation boundaries:
  - value L_MAX plus an occupied update stays L_MAX.
  - value L_MIN plus a free update stays L_MIN.
  - Clamp asserts no other flag.

Optional Feature:
- Macro OCC_UPDATE_STATS_EN.
- When defined, adds outputs free_count and occ_count (32 bits each):
  - Each increments on every accepted free/occupied request.
  - They do not count drops.
  - They reset to 0 on reset and on entry to CLEAR, and wrap at 2^32.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single update: x=3, y=5, occupied, RAM=0 → map_rd_addr=0x0503 at N; map_wr_en at N+2 with addr 0x0503, data 9.
- Back-to-back same cell: three occupied to (1,1), then a free update one cycle later → writes 9, 18, 27, 24, with no stale reads.
- Gap-of-one forwarding: occupied (2,2), occupied (4,4), occupied (2,2) on consecutive cycles → (2,2) writes 9 then 18, the second via W.
- Saturation: cell preloaded to 120, occupied → 127; cell at -126, free → -127.
- Clear (INDEX_W=4): clear_start with 2 requests in flight → both writes complete, then 256 zero writes at addr 0..255, busy falls after the last. write_enable during the sweep → no read, overrun=1.
- Reset asserted mid-CLEAR at addr 100 → next cycle map_wr_en=0, busy=0, state IDLE, overrun=0.

Source files
------------

// File: rtl/occupancy_update.sv
// occupancy_update: pipelined log-odds read-modify-write of the occupancy map with a map-clear sweep.
// Define OCC_UPDATE_STATS_EN to add the free_count/occ_count request counters.
module occupancy_update #(
    parameter int INDEX_W = 8,
    parameter int CELL_W  = 8,
    parameter int L_FREE  = 3,
    parameter int L_OCC   = 9,
    parameter int L_MIN   = -127,
    parameter int L_MAX   = 127
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [INDEX_W-1:0]       x_index,
    input  logic [INDEX_W-1:0]       y_index,
    input  logic                     cell_is_free,
    input  logic                     write_enable,
    input  logic                     clear_start,
    output logic                     map_rd_en,
    output logic [2*INDEX_W-1:0]     map_rd_addr,
    input  logic signed [CELL_W-1:0] map_rd_data,
    output logic                     map_wr_en,
    output logic [2*INDEX_W-1:0]     map_wr_addr,
    output logic signed [CELL_W-1:0] map_wr_data,
    output logic                     busy,
    output logic                     overrun
`ifdef OCC_UPDATE_STATS_EN
    ,
    output logic [31:0]              free_count,
    output logic [31:0]              occ_count
`endif
);
    localparam int AW = 2 * INDEX_W;
    localparam int SW = CELL_W + 2;
    localparam logic signed [SW-1:0] C_MIN   = SW'(L_MIN);
    localparam logic signed [SW-1:0] C_MAX   = SW'(L_MAX);
    localparam logic signed [SW-1:0] C_DFREE = SW'(-L_FREE);
    localparam logic signed [SW-1:0] C_DOCC  = SW'(L_OCC);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t                   r_state, w_state_nxt;
    logic                     r_s1_valid, r_s1_free, r_s2_valid, r_w_valid, r_overrun;
    logic [AW-1:0]            r_s1_addr, r_s2_addr, r_w_addr, r_clr_addr;
    logic signed [CELL_W-1:0] r_s2_data, r_w_data;
    logic                     w_accept, w_drop, w_clear_go, w_clear_done;
    logic signed [CELL_W-1:0] w_old, w_new;
    logic signed [SW-1:0]     w_sum;

    always_comb begin
        w_accept     = write_enable && r_state == IDLE;
        w_drop       = write_enable && r_state != IDLE;
        w_clear_go   = clear_start && r_state == IDLE;
        w_clear_done = r_state == CLEAR && r_clr_addr == '1;
        w_state_nxt  = r_state == IDLE  ? (clear_start ? DRAIN : IDLE) :
                       r_state == DRAIN ? ((!r_s1_valid && !r_s2_valid) ? CLEAR : DRAIN) :
                       (w_clear_done ? IDLE : CLEAR);
        // The write in S2 lands this cycle and W landed last cycle; neither is visible in map_rd_data yet.
        w_old = (r_s2_valid && r_s2_addr == r_s1_addr) ? r_s2_data :
                (r_w_valid && r_w_addr == r_s1_addr) ? r_w_data : map_rd_data;
        w_sum = SW'(w_old) + (r_s1_free ? C_DFREE : C_DOCC);
        w_new = w_sum > C_MAX ? CELL_W'(C_MAX) :
                w_sum < C_MIN ? CELL_W'(C_MIN) : w_sum[CELL_W-1:0];
        map_rd_en   = w_accept && !reset;
        map_rd_addr = map_rd_en ? {y_index, x_index} : '0;
        map_wr_en   = !reset && (r_state == CLEAR || r_s2_valid);
        map_wr_addr = !map_wr_en ? '0 : r_state == CLEAR ? r_clr_addr : r_s2_addr;
        map_wr_data = (!map_wr_en || r_state == CLEAR) ? '0 : r_s2_data;
        busy        = r_state != IDLE || r_s1_valid || r_s2_valid;
        overrun     = r_overrun;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_s1_valid <= 1'b0;
            r_s1_free  <= 1'b0;
            r_s1_addr  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_data  <= '0;
            r_w_valid  <= 1'b0;
            r_w_addr   <= '0;
            r_w_data   <= '0;
            r_clr_addr <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_s1_valid <= w_accept;
            r_s1_free  <= cell_is_free;
            r_s1_addr  <= {y_index, x_index};
            r_s2_valid <= r_s1_valid;
            r_s2_addr  <= r_s1_addr;
            r_s2_data  <= w_new;
            if (r_s2_valid) begin
                r_w_valid <= 1'b1;
                r_w_addr  <= r_s2_addr;
                r_w_data  <= r_s2_data;
            end else if (w_clear_done) begin
                r_w_valid <= 1'b0;
            end
            r_clr_addr <= r_state == CLEAR ? r_clr_addr + 1'b1 : '0;
            if (w_drop)
                r_overrun <= 1'b1;
            else if (w_clear_go)
                r_overrun <= 1'b0;
        end
    end

`ifdef OCC_UPDATE_STATS_EN
    logic [31:0] r_free_count, r_occ_count;

    always_ff @(posedge clock) begin
        if (reset || (r_state == DRAIN && w_state_nxt == CLEAR)) begin
            r_free_count <= '0;
            r_occ_count  <= '0;
        end else if (w_accept) begin
            if (cell_is_free)
                r_free_count <= r_free_count + 1'b1;
            else
                r_occ_count <= r_occ_count + 1'b1;
        end
    end

    assign free_count = r_free_count;
    assign occ_count  = r_occ_count;
`endif
endmodule
